btn_conditioner: RTL

// - Upstream front end for the lock FSM: turns raw, bouncy, asynchronous pushbuttons into clean single-cycle pulses in the clk domain.
// - Captures the 7-bit code switch bus in the same cycle as a press, so the FSM sees a matched {pulse, code} pair.
// - Lock wiring: btn_raw[0] = set_password, btn_raw[1] = check_password, code_raw = password switches.
// - The FSM is fully synchronous on clk and never uses a button as a clock.

---
 rtl/btn_conditioner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-flop synchronizers, per-button debounce with registered press/release
// pulses, and code capture on press. Long-press detection is built only with BTN_LONG_PRESS_EN.
module btn_conditioner #(
  parameter int NBTN            = 2,
  parameter int CODE_W          = 7,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BTN_ACTIVE_LOW  = 0,
  parameter int LONG_CYCLES     = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBTN-1:0]   btn_raw,
  input  logic [CODE_W-1:0] code_raw,
  output logic [NBTN-1:0]   btn_level,
  output logic [NBTN-1:0]   press_pulse,
  output logic [NBTN-1:0]   release_pulse,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  output logic [NBTN-1:0]   long_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NBTN-1:0] POL_MASK = (BTN_ACTIVE_LOW != 0) ? {NBTN{1'b1}} : {NBTN{1'b0}};

  logic [NBTN-1:0]   btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [CODE_W-1:0] code_meta_q, code_meta_d, code_sync_q, code_sync_d;
  logic [NBTN-1:0]   btn_s;
  logic [NBTN-1:0]   stable_q, stable_d;
  logic [NBTN-1:0]   press_q, press_d;
  logic [NBTN-1:0]   release_q, release_d;
  logic [CNT_W-1:0]  cnt_q [NBTN];
  logic [CNT_W-1:0]  cnt_d [NBTN];
  logic [CODE_W-1:0] code_q, code_d;
  logic              code_valid_q, code_valid_d;

  // Next-state for synchronizers, debounce counters, pulses and code capture.
  always_comb begin
    btn_meta_d  = btn_raw;
    btn_sync_d  = btn_meta_q;
    code_meta_d = code_raw;
    code_sync_d = code_meta_q;
    btn_s       = btn_sync_q ^ POL_MASK;
    stable_d    = stable_q;
    press_d     = {NBTN{1'b0}};
    release_d   = {NBTN{1'b0}};
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (btn_s[i] == stable_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        // The pulse is decided in the same cycle the stable level flips.
        stable_d[i]  = btn_s[i];
        press_d[i]   = btn_s[i];
        release_d[i] = ~btn_s[i];
        cnt_d[i]     = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    code_valid_d = |press_d;
    if (code_valid_d) begin
      code_d = code_sync_q;
    end else begin
      code_d = code_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q   <= {NBTN{1'b0}};
      btn_sync_q   <= {NBTN{1'b0}};
      code_meta_q  <= {CODE_W{1'b0}};
      code_sync_q  <= {CODE_W{1'b0}};
      stable_q     <= {NBTN{1'b0}};
      press_q      <= {NBTN{1'b0}};
      release_q    <= {NBTN{1'b0}};
      code_q       <= {CODE_W{1'b0}};
      code_valid_q <= 1'b0;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
      code_meta_q  <= code_meta_d;
      code_sync_q  <= code_sync_d;
      stable_q     <= stable_d;
      press_q      <= press_d;
      release_q    <= release_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level     = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign code_out      = code_q;
  assign code_valid    = code_valid_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q [NBTN];
  logic [HOLD_W-1:0] hold_d [NBTN];
  logic [NBTN-1:0]   long_q, long_d;

  // Hold counters saturate at LONG_CYCLES so the long pulse fires once per press.
  always_comb begin
    long_d = {NBTN{1'b0}};
    for (int i = 0; i < NBTN; i++) begin
      if (!stable_q[i]) begin
        hold_d[i] = {HOLD_W{1'b0}};
      end else if (hold_q[i] != HOLD_MAX) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        long_d[i] = (hold_q[i] == HOLD_LAST);
      end else begin
        hold_d[i] = hold_q[i];
      end
    end
  end

  // Long-press registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= {NBTN{1'b0}};
      for (int i = 0; i < NBTN; i++) begin
        hold_q[i] <= {HOLD_W{1'b0}};
      end
    end else begin
      long_q <= long_d;
      for (int i = 0; i < NBTN; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = {NBTN{1'b0}};
`endif

endmodule
